// File: rtl/mem_patt_chk_if.sv
// Pattern-checker data path bundle: write-address/pattern pair and in-order read beats.
// master = RAM-side driver, slave = checker.
interface mem_patt_chk_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;

    modport master (
        output wr_addr,
        output rd_data,
        output rd_data_valid,
        input  wr_data
    );

    modport slave (
        input  wr_addr,
        input  rd_data,
        input  rd_data_valid,
        output wr_data
    );
endinterface

// File: rtl/mem_patt_chk.sv
// Address-derived pattern generator and in-order read checker; err_cnt/pass/fail update one cycle after a beat.
// No backpressure: every rd_data_valid beat in RUN is consumed; a stalled stream ends the run via timeout.
module mem_patt_chk #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 24,
    parameter int          NUM_WORDS  = 503,
    parameter logic [31:0] SEED       = 32'hA5A5_5A5A,
    parameter int          TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    mem_patt_chk_if.slave         ram,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] beat_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_data
);
    localparam int                    PW       = DATA_WIDTH + ADDR_WIDTH + 32;
    localparam int                    TW       = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [TW-1:0]         TMO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [15:0]           ERR_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic                  start_q;
    logic                  start_rise;
    logic                  enter_run;
    logic                  beat;
    logic                  last_beat;
    logic                  mismatch;
    logic                  expire;
    logic [TW-1:0]         tmo_cnt;
    logic [15:0]           err_nxt;
    logic [DATA_WIDTH-1:0] exp_data;

    // Widen both operands before the XOR so any DATA/ADDR width mix zero-extends cleanly.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] idx);
        return DATA_WIDTH'(PW'(idx) ^ PW'(SEED));
    endfunction

    assign ram.wr_data = pattern(ram.wr_addr);
    assign busy        = (state == S_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= start;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_rise = start & ~start_q;
        enter_run  = 1'b0;
        exp_data   = pattern(beat_cnt);
        beat       = (state == S_RUN) && ram.rd_data_valid;
        last_beat  = beat && (beat_cnt == LAST_IDX);
        mismatch   = beat && (ram.rd_data != exp_data);
        // A beat on the expiry cycle wins, so expiry requires an idle cycle.
        expire     = (state == S_RUN) && !ram.rd_data_valid && (tmo_cnt == TMO_MAX);
        err_nxt    = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 16'd1 : err_cnt;

        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_nxt = S_RUN;
                    enter_run = 1'b1;
                end
            end
            S_RUN: begin
                if (last_beat || expire) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start_rise) begin
                    state_nxt = S_RUN;
                    enter_run = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            beat_cnt       <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            tmo_cnt        <= '0;
        end else if (enter_run) begin
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            beat_cnt       <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            tmo_cnt        <= '0;
        end else if (state == S_RUN) begin
            if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                tmo_cnt  <= '0;
                err_cnt  <= err_nxt;
                if (mismatch && (err_cnt == 16'd0)) begin
                    first_err_idx  <= beat_cnt;
                    first_err_data <= ram.rd_data;
                end
                if (last_beat) begin
                    pass <= (err_nxt == 16'd0);
                    fail <= (err_nxt != 16'd0);
                end
            end else if (expire) begin
                fail    <= 1'b1;
                timeout <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_patt_chk.sv
// Directed bench for mem_patt_chk with a per-beat scoreboard of expected err_cnt/beat_cnt.
module tb_mem_patt_chk;
    localparam int          DW      = 32;
    localparam int          AW      = 24;
    localparam int          NW      = 503;
    localparam logic [31:0] SEED    = 32'hA5A5_5A5A;
    localparam int          TMO     = 4096;

    typedef struct {
        logic [15:0] err;
        logic [23:0] beat;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy, pass, fail, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] beat_cnt, first_err_idx;
    logic [DW-1:0] first_err_data;

    int            total = 0;
    int            bad   = 0;
    exp_t          sbq[$];
    logic [23:0]   m_beat;
    logic [15:0]   m_err;
    logic [23:0]   m_first_idx;
    logic [31:0]   m_first_data;

    mem_patt_chk_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram ();

    mem_patt_chk #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .SEED(SEED), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ram(ram),
        .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
        .err_cnt(err_cnt), .beat_cnt(beat_cnt),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [23:0] i);
        return {8'h00, i} ^ SEED;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one beat (optionally corrupted), models its effect, checks err_cnt/beat_cnt one cycle later.
    task automatic send_beat(input logic [31:0] xmask);
        exp_t e;
        ram.rd_data       = pat(m_beat) ^ xmask;
        ram.rd_data_valid = 1'b1;
        if (xmask != 32'h0) begin
            if (m_err == 16'd0) begin
                m_first_idx  = m_beat;
                m_first_data = pat(m_beat) ^ xmask;
            end
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        m_beat = m_beat + 24'd1;
        e.err  = m_err;
        e.beat = m_beat;
        sbq.push_back(e);
        @(negedge clk);
        ram.rd_data_valid = 1'b0;
        if (sbq.size() == 0) begin
            chk("sbq_empty", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk("beat_err_cnt", 64'(err_cnt), 64'(e.err));
            chk("beat_beat_cnt", 64'(beat_cnt), 64'(e.beat));
        end
    endtask

    task automatic run_beats(input int n, input int maxgap, input int c0, input int c1,
                             input int c2, input logic [31:0] mask);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            if (int'(m_beat) == c0 || int'(m_beat) == c1 || int'(m_beat) == c2)
                send_beat(mask);
            else
                send_beat(32'h0);
        end
    endtask

    task automatic start_run();
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        m_beat = 0; m_err = 0; m_first_idx = 0; m_first_data = 0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("start_err_cnt", 64'(err_cnt), 64'd0);
        chk("start_flags", 64'({pass, fail, timeout}), 64'd0);
        chk("start_first_err", 64'({first_err_idx, first_err_data}), 64'd0);
    endtask

    task automatic check_end(input logic exp_pass, input logic exp_tmo);
        chk("end_pass", 64'(pass), 64'(exp_pass));
        chk("end_fail", 64'(fail), 64'(!exp_pass));
        chk("end_timeout", 64'(timeout), 64'(exp_tmo));
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_err_cnt", 64'(err_cnt), 64'(m_err));
        chk("end_beat_cnt", 64'(beat_cnt), 64'(m_beat));
        chk("end_first_idx", 64'(first_err_idx), 64'(m_first_idx));
        chk("end_first_data", 64'(first_err_data), 64'(m_first_data));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        ram.wr_addr = '0; ram.rd_data = '0; ram.rd_data_valid = 1'b0;
        m_beat = 0; m_err = 0; m_first_idx = 0; m_first_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 64'({busy, pass, fail, timeout}), 64'd0);
        chk("rst_counts", 64'({err_cnt, beat_cnt}), 64'd0);
        chk("rst_first_err", 64'({first_err_idx, first_err_data}), 64'd0);
        chk("wr_data_0", 64'(ram.wr_data), 64'(32'hA5A5_5A5A));
        reset = 1'b1;
        @(negedge clk);

        ram.wr_addr = 24'd1;
        #1 chk("wr_data_1", 64'(ram.wr_data), 64'(32'hA5A5_5A5B));
        ram.wr_addr = 24'hFF_FFFF;
        #1 chk("wr_data_max", 64'(ram.wr_data), 64'(32'hA55A_A5A5));

        // Valid pulses while idle are ignored.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ram.rd_data = 32'hDEAD_0000 + 32'(k);
            ram.rd_data_valid = 1'b1;
        end
        @(negedge clk);
        ram.rd_data_valid = 1'b0;
        chk("idle_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Clean run with random gaps; start stays high throughout.
        start_run();
        run_beats(NW, 10, -1, -1, -1, 32'h0);
        check_end(1'b1, 1'b0);

        // Valid pulses in DONE are ignored.
        ram.rd_data_valid = 1'b1;
        repeat (2) @(negedge clk);
        ram.rd_data_valid = 1'b0;
        chk("done_beat_cnt", 64'(beat_cnt), 64'(NW));
        chk("done_pass_hold", 64'({pass, fail}), 64'b10);

        // Single corruption; also a start rise mid-run must not restart.
        start_run();
        run_beats(100, 2, 17, -1, -1, 32'h1);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("run_restart_ignored", 64'(beat_cnt), 64'd100);
        chk("run_restart_busy", 64'(busy), 64'd1);
        run_beats(NW - 100, 2, 17, -1, -1, 32'h1);
        check_end(1'b0, 1'b0);
        chk("single_first_data", 64'(first_err_data), 64'(pat(24'd17) ^ 32'h1));

        // Multiple errors, back-to-back beats.
        start_run();
        run_beats(NW, 0, 3, 4, 400, 32'h0000_0100);
        check_end(1'b0, 1'b0);
        chk("multi_err_cnt", 64'(err_cnt), 64'd3);
        chk("multi_first_idx", 64'(first_err_idx), 64'd3);

        // Saturation: preload the counter near full, then keep corrupting.
        start_run();
        run_beats(10, 0, -1, -1, -1, 32'h0);
        force dut.err_cnt = 16'hFFFD;
        @(negedge clk);
        release dut.err_cnt;
        @(negedge clk);
        m_err = 16'hFFFD;
        run_beats(4, 0, 10, 11, 12, 32'h4);
        run_beats(1, 0, 13, -1, -1, 32'h4);
        chk("sat_err_cnt", 64'(err_cnt), 64'hFFFF);
        run_beats(NW - 15, 0, -1, -1, -1, 32'h0);
        check_end(1'b0, 1'b0);

        // Timeout: silence after 10 beats expires exactly TIMEOUT cycles later.
        start_run();
        run_beats(10, 3, -1, -1, -1, 32'h0);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_not_yet", 64'({busy, fail, timeout}), 64'b100);
        @(negedge clk);
        check_end(1'b0, 1'b1);

        // A beat on the expiry cycle keeps the run alive.
        start_run();
        run_beats(10, 3, -1, -1, -1, 32'h0);
        repeat (TMO - 1) @(negedge clk);
        send_beat(32'h0);
        chk("tmo_beat_wins", 64'({busy, fail, timeout}), 64'b100);
        run_beats(NW - 11, 1, -1, -1, -1, 32'h0);
        check_end(1'b1, 1'b0);

        // Reset mid-run clears outputs asynchronously; fresh run then passes.
        start_run();
        run_beats(200, 1, 5, -1, -1, 32'h10);
        #2 reset = 1'b0;
        #1;
        chk("arst_flags", 64'({busy, pass, fail, timeout}), 64'd0);
        chk("arst_counts", 64'({err_cnt, beat_cnt}), 64'd0);
        chk("arst_first_err", 64'({first_err_idx, first_err_data}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_run();
        run_beats(NW, 2, -1, -1, -1, 32'h0);
        check_end(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_patt_chk.md
Name: mem_patt_chk

Overview:
- Self-checking data stage wrapped around the LPDDR2 port-0 path. Drives write data and consumes read data.
- Write side: produces a deterministic address-derived write pattern on wr_data.
- Read side: consumes the in-order rd_data/rd_data_valid stream returned by the RAM interface and checks every word against the same pattern.
- Reports pass/fail, an error count, first-failure capture and a read timeout, for In-System Sources and Probes readout.

Parameters:
- DATA_WIDTH, 32, width of wr_data/rd_data.
- ADDR_WIDTH, 24, width of wr_addr.
- NUM_WORDS, 503, read beats expected per test run (must be at least 1).
- SEED, 32'hA5A5_5A5A, pattern XOR seed; pattern(i) = zero-extended(i) XOR SEED, truncated to DATA_WIDTH.
- TIMEOUT, 4096, maximum clk cycles between read beats while running.

Ports:
- clk  input  1  single clock for all logic (read and write side share it).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level from ISSP; the rising edge is detected internally and arms a run.
- wr_addr  input  ADDR_WIDTH  current write address from the frame buffer address generator.
- wr_data  output  DATA_WIDTH  pattern(wr_addr); combinational from wr_addr.
- rd_data  input  DATA_WIDTH  read data from the RAM interface.
- rd_data_valid  input  1  read beat qualifier.
- busy  output  1  high in RUN.
- pass  output  1  sticky pass flag.
- fail  output  1  sticky fail flag.
- timeout  output  1  sticky; set when a fail is caused by the timeout.
- err_cnt  output  16  count of mismatching beats; saturates at 16'hFFFF.
- beat_cnt  output  ADDR_WIDTH  read beats received in the current run.
- first_err_idx  output  ADDR_WIDTH  beat index of the first mismatch.
- first_err_data  output  DATA_WIDTH  rd_data of the first mismatch.

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - All outputs 0 except wr_data, which always follows wr_addr.
  - The start edge-detect register is cleared.
- Start edge: start_q registers start; start_rise = start & ~start_q.
- States:
  - IDLE:
    - start_rise -> RUN.
    - On entry to RUN, clear beat_cnt, err_cnt, first_err_*, pass, fail, timeout and the timeout counter.
    - rd_data_valid is ignored in IDLE.
  - RUN:
    - On each rd_data_valid beat:
      - Compare rd_data with pattern(beat_cnt).
      - On mismatch, increment err_cnt (saturating). If err_cnt was 0, capture first_err_idx = beat_cnt and first_err_data = rd_data in the same cycle.
      - beat_cnt increments by 1.
      - The timeout counter clears.
    - On a beat where beat_cnt == NUM_WORDS-1:
      - Next state = DONE.
      - pass is set the next cycle if the final err_cnt, including this beat, is 0; otherwise fail is set.
    - On a cycle with no beat, the timeout counter increments. When it reaches TIMEOUT-1, the next state is DONE and fail = timeout = 1.
    - A beat and a timeout expiry in the same cycle: the beat wins and the timeout counter clears.
    - start_rise in RUN is ignored.
  - DONE:
    - Flags and captures hold.
    - rd_data_valid is ignored.
    - start_rise re-enters RUN with the same clearing as from IDLE.
- pass and fail are never both 1.
- busy = (state == RUN).
- Latency: a mismatch is visible on err_cnt one cycle after the beat; pass/fail are visible one cycle after the last beat.
- Checking is in-order only; the RAM interface guarantees in-order return.
- Asserting reset mid-run aborts immediately to IDLE with all outputs cleared.

Test Plan:
- Clean run: reset, start rise, return 503 beats of pattern(i) with gaps of 0–10 cycles -> pass=1 one cycle after beat 502, fail=0, err_cnt=0, beat_cnt=503, busy=0.
- Single corruption: beat 17 returns pattern(17)^32'h1 -> err_cnt=1, first_err_idx=17, first_err_data=pattern(17)^1, fail=1 and pass=0 after beat 502.
- Multiple errors: beats 3, 4 and 400 corrupted -> err_cnt=3, first_err_idx=3; back-to-back beats every cycle checked; saturation check by forcing err_cnt near 16'hFFFF holds at FFFF.
- Timeout: 10 beats, then silence -> fail=timeout=1 exactly TIMEOUT cycles after the last beat; a beat arriving on the expiry cycle prevents the timeout.
- Restart and ignore rules: start held high through RUN does not restart; from DONE a new start rise clears all flags and runs again to pass; rd_data_valid pulses in IDLE leave beat_cnt=0.
- Reset mid-run: assert reset at beat 200 -> all outputs 0 asynchronously; release then start -> fresh run passes. wr_data = wr_addr^SEED checked for wr_addr = 0, 1 and 24'hFFFFFF.
